// File: rtl/id_exe_pipe.sv
// ---------------------------------------------------------------------------
// id_exe_pipe
//
// ID/EXE pipeline register for a 5-stage in-order core.
//
// What it does:
//   - Detects a load-use hazard against the instruction in EXE and raises
//     stall, which is combinational.
//   - Loads a bubble into EXE on flush or stall. Flush has priority.
//   - Otherwise captures the decoded instruction.
//   - Masks unused source indices so the forwarding unit never matches them.
//   - Suppresses register writes to x0.
//   - Forwards same-cycle writeback data into the captured operands.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   id_*              decoded instruction fields from the ID stage
//   flush             taken branch/jump resolved in EXE; kills the ID slot
//   wb_reg_write,
//   wb_rd_addr,
//   wb_data           writeback port used for write-through
//   stall             hold PC and IF/ID this cycle
//   exe_*             registered instruction fields presented to EXE
//
// Optional feature (macro ID_EXE_STATS_EN):
//   stall_count and flush_count are 32-bit wrapping event counters.
// ---------------------------------------------------------------------------
module id_exe_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [15:0] id_ctrl,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        flush,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        exe_valid,
    output logic        exe_reg_write,
    output logic        exe_mem_read,
    output logic        exe_mem_write,
    output logic [31:0] exe_pc,
    output logic [31:0] exe_rs1_data,
    output logic [31:0] exe_rs2_data,
    output logic [31:0] exe_imm,
    output logic [15:0] exe_ctrl,
    output logic [4:0]  exe_rs1_addr,
    output logic [4:0]  exe_rs2_addr,
`ifdef ID_EXE_STATS_EN
    output logic [4:0]  exe_rd_addr,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`else
    output logic [4:0]  exe_rd_addr
`endif
);

    logic rs1_hit;
    logic rs2_hit;
    logic load_slot;
    logic rs1_wb_fwd;
    logic rs2_wb_fwd;

    // Load-use hazard.
    // A load in EXE produces its data too late for the instruction now in
    // ID, so that instruction must wait one cycle. A flush kills the ID slot
    // anyway, so a flush suppresses the stall.
    always_comb begin
        rs1_hit = id_use_rs1 && (id_rs1_addr == exe_rd_addr);
        rs2_hit = id_use_rs2 && (id_rs2_addr == exe_rd_addr);
        stall   = id_valid && exe_valid && exe_mem_read && (exe_rd_addr != 5'd0)
                  && (rs1_hit || rs2_hit) && !flush;
    end

    // A real instruction is captured only when nothing kills it.
    // The register file writes on the same edge we capture. Without
    // write-through, the operand read in ID would be stale.
    always_comb begin
        load_slot  = id_valid && !flush && !stall;
        rs1_wb_fwd = wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs1_addr);
        rs2_wb_fwd = wb_reg_write && (wb_rd_addr != 5'd0) && (wb_rd_addr == id_rs2_addr);
    end

    // EXE register.
    // A bubble is an all-zero entry. Zeroed addresses guarantee the bubble
    // can never match in the forwarding unit or in the hazard check above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_valid     <= 1'b0;
            exe_reg_write <= 1'b0;
            exe_mem_read  <= 1'b0;
            exe_mem_write <= 1'b0;
            exe_pc        <= 32'd0;
            exe_rs1_data  <= 32'd0;
            exe_rs2_data  <= 32'd0;
            exe_imm       <= 32'd0;
            exe_ctrl      <= 16'd0;
            exe_rs1_addr  <= 5'd0;
            exe_rs2_addr  <= 5'd0;
            exe_rd_addr   <= 5'd0;
        end else if (!load_slot) begin
            exe_valid     <= 1'b0;
            exe_reg_write <= 1'b0;
            exe_mem_read  <= 1'b0;
            exe_mem_write <= 1'b0;
            exe_pc        <= 32'd0;
            exe_rs1_data  <= 32'd0;
            exe_rs2_data  <= 32'd0;
            exe_imm       <= 32'd0;
            exe_ctrl      <= 16'd0;
            exe_rs1_addr  <= 5'd0;
            exe_rs2_addr  <= 5'd0;
            exe_rd_addr   <= 5'd0;
        end else begin
            exe_valid     <= 1'b1;
            exe_reg_write <= id_reg_write && (id_rd_addr != 5'd0);
            exe_mem_read  <= id_mem_read;
            exe_mem_write <= id_mem_write;
            exe_pc        <= id_pc;
            exe_rs1_data  <= rs1_wb_fwd ? wb_data : id_rs1_data;
            exe_rs2_data  <= rs2_wb_fwd ? wb_data : id_rs2_data;
            exe_imm       <= id_imm;
            exe_ctrl      <= id_ctrl;
            exe_rs1_addr  <= id_use_rs1 ? id_rs1_addr : 5'd0;
            exe_rs2_addr  <= id_use_rs2 ? id_rs2_addr : 5'd0;
            exe_rd_addr   <= id_rd_addr;
        end
    end

`ifdef ID_EXE_STATS_EN
    // Event counters.
    // They count every edge on which stall or flush is high, and wrap
    // naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_exe_pipe
//
// Scoreboard bench for id_exe_pipe.
//
// How it works:
//   - Every stimulus cycle, the reference model predicts the combinational
//     stall value and the EXE contents after the next rising edge.
//   - Both predictions are pushed into queues.
//   - Independent monitor processes pop the queues and compare them against
//     the DUT.
//
// Define ID_EXE_STATS_EN to also check the event counters.
// ---------------------------------------------------------------------------
module tb_id_exe_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use1;
        logic        use2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        fl;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
    } exe_t;

    typedef struct packed {
        exe_t        exe;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic        id_use_rs1;
    logic        id_use_rs2;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        exe_valid;
    logic        exe_reg_write;
    logic        exe_mem_read;
    logic        exe_mem_write;
    logic [31:0] exe_pc;
    logic [31:0] exe_rs1_data;
    logic [31:0] exe_rs2_data;
    logic [31:0] exe_imm;
    logic [15:0] exe_ctrl;
    logic [4:0]  exe_rs1_addr;
    logic [4:0]  exe_rs2_addr;
    logic [4:0]  exe_rd_addr;
    logic [31:0] stall_count;
    logic [31:0] flush_count;

    int   checks = 0;
    int   errors = 0;
    exe_t model_exe = '0;
    logic [31:0] model_stalls = 32'd0;
    logic [31:0] model_flushes = 32'd0;
    logic stall_q[$];
    exp_t exe_q[$];

    always #5 clk = ~clk;

    id_exe_pipe dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .stall(stall), .exe_valid(exe_valid), .exe_reg_write(exe_reg_write),
        .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
        .exe_pc(exe_pc), .exe_rs1_data(exe_rs1_data), .exe_rs2_data(exe_rs2_data),
        .exe_imm(exe_imm), .exe_ctrl(exe_ctrl),
        .exe_rs1_addr(exe_rs1_addr), .exe_rs2_addr(exe_rs2_addr),
`ifdef ID_EXE_STATS_EN
        .exe_rd_addr(exe_rd_addr), .stall_count(stall_count), .flush_count(flush_count)
`else
        .exe_rd_addr(exe_rd_addr)
`endif
    );

`ifndef ID_EXE_STATS_EN
    assign stall_count = 32'd0;
    assign flush_count = 32'd0;
`endif

    function automatic exe_t dut_exe();
        exe_t e;
        e.valid = exe_valid;     e.rw   = exe_reg_write;
        e.mr    = exe_mem_read;  e.mw   = exe_mem_write;
        e.pc    = exe_pc;        e.d1   = exe_rs1_data;
        e.d2    = exe_rs2_data;  e.imm  = exe_imm;
        e.ctrl  = exe_ctrl;      e.a1   = exe_rs1_addr;
        e.a2    = exe_rs2_addr;  e.rd   = exe_rd_addr;
        return e;
    endfunction

    // A consumer must wait when the instruction ahead of it is a load whose
    // destination (never x0) is a register the consumer reads.
    function automatic logic model_stall(stim_t s);
        logic pending_load;
        logic reads_it;
        pending_load = model_exe.valid && model_exe.mr && (model_exe.rd != 5'd0);
        reads_it = (s.use1 && s.rs1 == model_exe.rd) || (s.use2 && s.rs2 == model_exe.rd);
        return s.valid && !s.fl && pending_load && reads_it;
    endfunction

    // Read a source register as seen at the end of this cycle, including the
    // value being written back right now.
    function automatic logic [31:0] reg_value(stim_t s, logic [4:0] r, logic [31:0] rf_val);
        if (s.wb_we && s.wb_rd != 5'd0 && s.wb_rd == r) return s.wb_d;
        return rf_val;
    endfunction

    function automatic exe_t model_next(stim_t s, logic st);
        exe_t n;
        n = '0;
        if (s.valid && !s.fl && !st) begin
            n.valid = 1'b1;
            n.pc    = s.pc;
            n.imm   = s.imm;
            n.ctrl  = s.ctrl;
            n.mr    = s.mr;
            n.mw    = s.mw;
            n.rd    = s.rd;
            n.rw    = s.rw && (s.rd != 5'd0);
            n.a1    = s.use1 ? s.rs1 : 5'd0;
            n.a2    = s.use2 ? s.rs2 : 5'd0;
            n.d1    = reg_value(s, s.rs1, s.d1);
            n.d2    = reg_value(s, s.rs2, s.d2);
        end
        return n;
    endfunction

    task automatic applyStimulus(input stim_t s);
        logic st;
        exp_t e;
        @(negedge clk);
        id_valid = s.valid;        id_pc = s.pc;
        id_rs1_addr = s.rs1;       id_rs2_addr = s.rs2;   id_rd_addr = s.rd;
        id_use_rs1 = s.use1;       id_use_rs2 = s.use2;
        id_rs1_data = s.d1;        id_rs2_data = s.d2;    id_imm = s.imm;
        id_ctrl = s.ctrl;          id_reg_write = s.rw;
        id_mem_read = s.mr;        id_mem_write = s.mw;
        flush = s.fl;              wb_reg_write = s.wb_we;
        wb_rd_addr = s.wb_rd;      wb_data = s.wb_d;
        st = model_stall(s);
        stall_q.push_back(st);
        model_exe = model_next(s, st);
        if (st) model_stalls = model_stalls + 32'd1;
        if (s.fl) model_flushes = model_flushes + 32'd1;
        e.exe = model_exe;
        e.stalls = model_stalls;
        e.flushes = model_flushes;
        exe_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp_v);
        end
    endtask

    // The stall monitor samples mid-cycle, well after the stimulus settles.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() != 0) checkOutput("stall", {191'd0, stall}, {191'd0, stall_q.pop_front()});
        end
    end

    // The EXE monitor samples just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exe_q.size() != 0) begin
                e = exe_q.pop_front();
                checkOutput("exe_regs", {29'd0, dut_exe()}, {29'd0, e.exe});
`ifdef ID_EXE_STATS_EN
                checkOutput("counters", {128'd0, stall_count, flush_count}, {128'd0, e.stalls, e.flushes});
`endif
            end
        end
    end

    function automatic stim_t blank();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.valid = ($urandom_range(0, 7) != 0);
        s.pc    = $urandom;
        s.rs1   = 5'($urandom_range(0, 7));
        s.rs2   = 5'($urandom_range(0, 7));
        s.rd    = 5'($urandom_range(0, 7));
        s.use1  = 1'($urandom_range(0, 1));
        s.use2  = 1'($urandom_range(0, 1));
        s.d1    = $urandom;
        s.d2    = $urandom;
        s.imm   = $urandom;
        s.ctrl  = 16'($urandom);
        s.rw    = 1'($urandom_range(0, 1));
        s.mr    = 1'($urandom_range(0, 1));
        s.mw    = 1'($urandom_range(0, 1));
        s.fl    = ($urandom_range(0, 9) == 0);
        s.wb_we = 1'($urandom_range(0, 1));
        s.wb_rd = 5'($urandom_range(0, 7));
        s.wb_d  = $urandom;
        return s;
    endfunction

    initial begin
        stim_t s;
        stim_t lw;
        stim_t use_i;
        rst = 1'b1;
        id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_ctrl = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; flush = 0;
        wb_reg_write = 0; wb_rd_addr = 0; wb_data = 0;
        #12;
        checkOutput("reset_exe", {29'd0, dut_exe()}, 192'd0);
        checkOutput("reset_stall", {191'd0, stall}, 192'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load to x5 followed by a consumer of x5.
        // The consumer is held in ID for one extra cycle.
        lw = blank(); lw.valid = 1; lw.pc = 32'h100; lw.rd = 5'd5; lw.rw = 1; lw.mr = 1;
        lw.rs1 = 5'd2; lw.use1 = 1; lw.imm = 32'h8;
        applyStimulus(lw);
        use_i = blank(); use_i.valid = 1; use_i.pc = 32'h104; use_i.rs1 = 5'd5; use_i.use1 = 1;
        use_i.rs2 = 5'd6; use_i.use2 = 1; use_i.rd = 5'd7; use_i.rw = 1; use_i.ctrl = 16'h0011;
        use_i.d1 = 32'h1234; use_i.d2 = 32'h5678;
        applyStimulus(use_i);
        applyStimulus(use_i);
        @(posedge clk);
        #2;
        checkOutput("add_rs1_addr", {187'd0, exe_rs1_addr}, {187'd0, 5'd5});

        // Load to x0 followed by a consumer of x0: no hazard, and no register write.
        lw.rd = 5'd0;
        applyStimulus(lw);
        use_i.rs1 = 5'd0;
        applyStimulus(use_i);

        // Writeback to x7 in the same cycle as a consumer reading x7.
        s = blank(); s.valid = 1; s.pc = 32'h200; s.rs2 = 5'd7; s.use2 = 1; s.d2 = 32'h1;
        s.wb_we = 1; s.wb_rd = 5'd7; s.wb_d = 32'hDEADBEEF; s.rd = 5'd3; s.rw = 1;
        applyStimulus(s);

        // A flush arriving during a load-use condition.
        lw.rd = 5'd4;
        applyStimulus(lw);
        use_i.rs1 = 5'd4; use_i.fl = 1;
        applyStimulus(use_i);
        use_i.fl = 0;

        // An unused rs2 index must not reach the forwarding unit.
        s = blank(); s.valid = 1; s.pc = 32'h300; s.rs2 = 5'd9; s.use2 = 0; s.rs1 = 5'd1;
        s.use1 = 1; s.d2 = 32'h55;
        applyStimulus(s);

        for (int i = 0; i < 200; i++) applyStimulus(rand_stim());

        // Reset pulse mid-stream.
        // The outputs must clear with no clock edge in between.
        s = blank(); s.valid = 1; s.pc = 32'h400; s.rd = 5'd6; s.rw = 1; s.mr = 1; s.fl = 1;
        applyStimulus(s);
        s.fl = 0;
        applyStimulus(s);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_exe", {29'd0, dut_exe()}, 192'd0);
        checkOutput("midreset_stall", {191'd0, stall}, 192'd0);
`ifdef ID_EXE_STATS_EN
        checkOutput("midreset_counters", {128'd0, stall_count, flush_count}, 192'd0);
`endif
        #1;
        rst = 1'b0;
        model_exe = '0;
        model_stalls = 32'd0;
        model_flushes = 32'd0;

        // The first edge after reset release performs a normal load.
        for (int i = 0; i < 100; i++) applyStimulus(rand_stim());

        for (int i = 0; i < 10 && (exe_q.size() != 0 || stall_q.size() != 0); i++) @(posedge clk);
        #3;
        checkOutput("queues_drained", {160'd0, 32'(exe_q.size() + stall_q.size())}, 192'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
